draw_ball: RTL
==============

// Module: draw_ball
//
// PURPOSE
// - Sprite overlay stage feeding the ball image ROM and consuming its pixel data.
// - Takes the VGA timing/pixel stream and a ball position, computes the ROM address for the current pixel and drives it to the ROM.
// - Replaces background RGB with the returned ball pixel inside the ball box; delays all timing signals to stay aligned.
// - Sits between the background/goal draw stage and the player/UI overlay stages in the VGA chain.
//
// PARAMETERS
// - BALL_W      48     ball sprite width in pixels
// - BALL_H      48     ball sprite height in pixels
// - ADDR_WIDTH  12     ROM address width; must satisfy BALL_W*BALL_H <= 2**ADDR_WIDTH
// - DATA_WIDTH  12     RGB width (4:4:4); equals the ROM data width
// - KEY_COLOR   12'hF0F  transparent colour, used only with BALL_TRANSPARENCY_EN
//
// PORTS
// - clk         in   1           pixel clock, posedge active
// - rst_n       in   1           asynchronous reset, active-low
// - hcount_in   in   11          horizontal pixel counter
// - vcount_in   in   11          vertical line counter
// - hsync_in / vsync_in / hblnk_in / vblnk_in   in  1 each   VGA timing
// - rgb_in      in   DATA_WIDTH  background pixel
// - xpos        in   11          ball top-left x (screen coords)
// - ypos        in   11          ball top-left y
// - ball_en     in   1           draw ball when 1
// - rom_addr    out  ADDR_WIDTH  address to ball ROM (registered)
// - rom_data    in   DATA_WIDTH  ROM data, valid one clk after rom_addr
// - hcount_out / vcount_out  out  11         delayed counters
// - hsync_out / vsync_out / hblnk_out / vblnk_out  out  1 each  delayed timing
// - rgb_out     out  DATA_WIDTH  composited pixel
//
// BEHAVIOUR
// - Reset (rst_n=0, async): all outputs 0, rom_addr 0, latched pos/enable 0, pipeline flags 0.
// - Position latch: xpos/ypos/ball_en captured into x_lat/y_lat/en_lat on rising edge of vblnk_in
//   (vblnk_in=1 this clk, 0 previous clk). Values held for the whole frame -> no tearing.
//   Changes of xpos/ypos outside that edge have no effect until next frame.
// - Stage 1 (edge 1): in_box = en_lat && hcount_in in [x_lat, x_lat+BALL_W) && vcount_in in [y_lat, y_lat+BALL_H)
//   && !hblnk_in && !vblnk_in. Comparisons done in 12 bits (no overflow at screen edge, box may be clipped).
//   rom_addr <= (vcount_in-y_lat)*BALL_W + (hcount_in-x_lat) when in_box, else held at previous value.
// - Stage 2 (edge 2): ROM registers rom_data; in_box delayed one stage.
// - Stage 3 (edge 3): rgb_out <= in_box_d2 ? rom_data : rgb_in_d2; blanking forces rgb_out 0.
// - Total latency 3 clk for every output; hcount/vcount/sync/blank/rgb delayed exactly 3 clk.
// - Pipeline states per clk: IDLE (outside box) / DRAW (inside box); no other FSM; box exits at x_lat+BALL_W-1 inclusive.
// - Reset mid-frame: pipeline flushed to 0; first valid outputs 3 clk after release; position stays 0 until next vblnk edge.
// - ball_en=0 latched: rgb_out equals delayed rgb_in, rom_addr frozen.
//
// CONFIGURATION
// - Macro BALL_TRANSPARENCY_EN:
//   defined   -> inside box, pixels with rom_data == KEY_COLOR output delayed rgb_in (round ball on grass).
//   undefined -> every in-box pixel outputs rom_data, KEY_COLOR has no effect.
//
// STRUCTURE
// - vga_pkg: HOR_PIXELS, VER_PIXELS, counter width (11), RGB width, KEY_COLOR default.
// - Sub-module delay (WIDTH, CLK_DEL params, async active-low reset) for 3-clk timing/rgb delay and 1-clk in_box delay.
// - Address multiply/compare and output mux stay in draw_ball.
//
// TESTING
// - Reset: hold rst_n=0 while stream runs -> all outputs 0; release -> outputs match inputs delayed 3 clk.
// - xpos=100,ypos=200,ball_en=1, vblnk edge: pixel (100,200) -> rom_addr 0; (147,247) -> rom_addr 2303; rgb_out = ROM model data 3 clk later.
// - Pixel (99,200) and (148,200) -> rgb_out = rgb_in delayed; rom_addr unchanged.
// - Change xpos to 300 mid-frame -> box stays at 100 until next vblnk rising edge, then moves to 300.
// - xpos=780 (clipped at 800) -> only columns 780..799 drawn, no wrap into column 0 of next line.
// - With BALL_TRANSPARENCY_EN, ROM returns 12'hF0F -> rgb_out = rgb_in; returns 12'hFFF -> rgb_out 12'hFFF.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants for the overlay chain: screen size, counter and RGB widths,
// default transparent colour.
package vga_pkg;

  localparam int unsigned HOR_PIXELS = 800;
  localparam int unsigned VER_PIXELS = 600;
  localparam int unsigned CNT_W      = 11;
  localparam int unsigned RGB_W      = 12;

  localparam logic [RGB_W-1:0] KEY_COLOR_DEF = 12'hF0F;

endpackage

// File: rtl/delay.sv
// Fixed-latency shift register with asynchronous active-low reset; CLK_DEL must be >= 1.
module delay #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [CLK_DEL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < CLK_DEL; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[CLK_DEL-1];

endmodule

// File: rtl/draw_ball.sv
// Ball sprite overlay: drives the ball ROM address and muxes its pixel over the background.
// Optional macro BALL_TRANSPARENCY_EN makes KEY_COLOR pixels show the background instead.
module draw_ball
  import vga_pkg::*;
#(
  parameter int unsigned            BALL_W     = 48,
  parameter int unsigned            BALL_H     = 48,
  parameter int unsigned            ADDR_WIDTH = 12,
  parameter int unsigned            DATA_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0]  KEY_COLOR  = DATA_WIDTH'(KEY_COLOR_DEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CNT_W-1:0]      hcount_in,
  input  logic [CNT_W-1:0]      vcount_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  hblnk_in,
  input  logic                  vblnk_in,
  input  logic [DATA_WIDTH-1:0] rgb_in,
  input  logic [CNT_W-1:0]      xpos,
  input  logic [CNT_W-1:0]      ypos,
  input  logic                  ball_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [CNT_W-1:0]      hcount_out,
  output logic [CNT_W-1:0]      vcount_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  hblnk_out,
  output logic                  vblnk_out,
  output logic [DATA_WIDTH-1:0] rgb_out
);

  localparam int unsigned TimW = 2 * CNT_W + 4;

  logic                  vblnk_prev_q;
  logic [CNT_W-1:0]      x_lat_q, y_lat_q;
  logic                  en_lat_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  in_box, in_box_q, in_box_d2;
  logic [CNT_W:0]        h_ext, v_ext, x_ext, y_ext;
  logic [ADDR_WIDTH-1:0] dx, dy;
  logic                  hblnk_d2, vblnk_d2;
  logic [DATA_WIDTH-1:0] rgb_d2, rgb_d, rgb_q;
  logic [TimW-1:0]       tim_out;

  // One extra bit so x_lat+BALL_W never wraps near the right/bottom screen edge.
  assign h_ext = {1'b0, hcount_in};
  assign v_ext = {1'b0, vcount_in};
  assign x_ext = {1'b0, x_lat_q};
  assign y_ext = {1'b0, y_lat_q};

  assign in_box = en_lat_q && !hblnk_in && !vblnk_in
                  && (h_ext >= x_ext) && (h_ext < x_ext + (CNT_W+1)'(BALL_W))
                  && (v_ext >= y_ext) && (v_ext < y_ext + (CNT_W+1)'(BALL_H));

  assign dx = ADDR_WIDTH'(h_ext - x_ext);
  assign dy = ADDR_WIDTH'(v_ext - y_ext);

  always_comb begin
    rom_addr_d = rom_addr_q;
    if (in_box) rom_addr_d = dy * ADDR_WIDTH'(BALL_W) + dx;
  end

  // Position is sampled only on the vblnk rising edge so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev_q <= 1'b0;
      x_lat_q      <= '0;
      y_lat_q      <= '0;
      en_lat_q     <= 1'b0;
      rom_addr_q   <= '0;
      in_box_q     <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      if (vblnk_in && !vblnk_prev_q) begin
        x_lat_q  <= xpos;
        y_lat_q  <= ypos;
        en_lat_q <= ball_en;
      end
      rom_addr_q <= rom_addr_d;
      in_box_q   <= in_box;
    end
  end

  assign rom_addr = rom_addr_q;

  delay #(
    .WIDTH   (1),
    .CLK_DEL (1)
  ) u_inbox_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (in_box_q),
    .dout_o (in_box_d2)
  );

  delay #(
    .WIDTH   (DATA_WIDTH + 2),
    .CLK_DEL (2)
  ) u_pix_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  ({hblnk_in, vblnk_in, rgb_in}),
    .dout_o ({hblnk_d2, vblnk_d2, rgb_d2})
  );

  delay #(
    .WIDTH   (TimW),
    .CLK_DEL (3)
  ) u_tim_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  ({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in}),
    .dout_o (tim_out)
  );

  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim_out;

  always_comb begin
    rgb_d = rgb_d2;
    if (hblnk_d2 || vblnk_d2) begin
      rgb_d = '0;
    end else if (in_box_d2) begin
`ifdef BALL_TRANSPARENCY_EN
      if (rom_data != KEY_COLOR) rgb_d = rom_data;
`else
      rgb_d = rom_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= '0;
    else        rgb_q <= rgb_d;
  end

  assign rgb_out = rgb_q;

endmodule
